// File: rtl/arch_defs_pkg.sv
// rtl/arch_defs_pkg.sv - shared architecture types and constants
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - down-counting baud tick generator
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count CLKS_PER_BIT-1 down to 0, reload on zero or on restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // tick marks the last cycle of the current bit period
  assign tick = (cnt == '0);

endmodule

// File: rtl/output_uart_tx.sv
// rtl/output_uart_tx.sv - sends output register values as hex text over UART
module output_uart_tx
  import arch_defs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SEND_CRLF    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] out_val,
  input  logic                  out_load,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [1:0] LAST_CHAR = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  logic [1:0]            rst_sync;
  logic                  rst_n_int;
  uart_state_t           state, state_n;
  logic [2:0]            bit_idx, bit_n;
  logic [1:0]            char_idx, char_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic [DATA_WIDTH-1:0] pend_data, pend_n;
  logic                  pend_valid, pv_n;
  logic                  overrun_q, ovr_n;
  logic                  busy_q;
  logic                  restart;
  logic                  tick;
  logic                  final_tick;
  logic [7:0]            cur_char;

  // Assert asynchronously, release two clocks after reset goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (rst_n_int),
    .restart(restart),
    .tick   (tick)
  );

  // Character currently on the line: two hex digits then optional CR, LF
  always_comb begin
    cur_char = ASCII_LF;
    case (char_idx)
      2'd0:    cur_char = hex_ascii(hold[7:4]);
      2'd1:    cur_char = hex_ascii(hold[3:0]);
      2'd2:    cur_char = ASCII_CR;
      default: cur_char = ASCII_LF;
    endcase
  end

  // Line level decoded from the registered frame position
  always_comb begin
    uart_tx = 1'b1;
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = cur_char[bit_idx];
      default: uart_tx = 1'b1;
    endcase
  end

  // Next-state, message holding and pending/overrun bookkeeping
  always_comb begin
    state_n    = state;
    bit_n      = bit_idx;
    char_n     = char_idx;
    hold_n     = hold;
    pend_n     = pend_data;
    pv_n       = pend_valid;
    ovr_n      = overrun_q;
    restart    = 1'b0;
    final_tick = (state == STOP) && tick && (char_idx == LAST_CHAR);

    case (state)
      IDLE: begin
        if (out_load) begin
          hold_n  = out_val;
          state_n = START;
          char_n  = 2'd0;
          restart = 1'b1;
        end else if (pend_valid) begin
          hold_n  = pend_data;
          pv_n    = 1'b0;
          state_n = START;
          char_n  = 2'd0;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (char_idx != LAST_CHAR) begin
            state_n = START;
            char_n  = char_idx + 2'd1;
          end else if (pend_valid) begin
            hold_n  = pend_data;
            pv_n    = 1'b0;
            state_n = START;
            char_n  = 2'd0;
          end else if (out_load) begin
            // Strobe on the very last cycle with nothing pending: start it directly
            hold_n  = out_val;
            state_n = START;
            char_n  = 2'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase

    // A strobe while a message is in flight parks the value in pending;
    // it only counts as an overrun if an unconsumed value gets overwritten
    if (out_load && (state != IDLE) && !(final_tick && !pend_valid)) begin
      pend_n = out_val;
      pv_n   = 1'b1;
      if (pend_valid && !final_tick) begin
        ovr_n = 1'b1;
      end
    end
  end

  // State register; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      char_idx   <= 2'd0;
      hold       <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_n;
      char_idx   <= char_n;
      hold       <= hold_n;
      pend_data  <= pend_n;
      pend_valid <= pv_n;
      overrun_q  <= ovr_n;
      busy_q     <= (state_n != IDLE) || pv_n;
    end
  end

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: doc/output_uart_tx.md
OUTPUT_UART_TX -- requirements
Module: output_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter SEND_CRLF, default 1; 1 appends CR, LF after the two hex digits.
REQ-003 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port out_val, input, DATA_WIDTH, value latched by the computer's output register.
REQ-006 SHALL have port out_load, input, 1, one-cycle strobe, high in the same cycle the output register latches out_val.
REQ-007 SHALL have port uart_tx, output, 1, serial line: 8N1, LSB first, idle high.
REQ-008 SHALL have port busy, output, 1, high while a message is being shifted out or is pending.
REQ-009 SHALL have port overrun, output, 1, sticky flag, set when a pending value is overwritten.

Function
REQ-010 SHALL transmit each accepted value as ASCII upper-case hex, high nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), followed by 0x0D and 0x0A when SEND_CRLF=1.
REQ-011 SHALL implement the FSM states IDLE, START, DATA, STOP, with a char index 0..3 (or 0..1 when SEND_CRLF=0).
REQ-012 In IDLE with out_load=1, SHALL capture out_val into the shift holding register and enter START at the next edge; uart_tx SHALL go low in the first cycle after the strobe edge.
REQ-013 SHALL hold each bit (start, d0..d7, stop) for exactly CLKS_PER_BIT cycles.
REQ-014 After STOP of a non-final char, SHALL enter START for the next char with no idle gap; after the final char, SHALL go to IDLE or to START if pending is valid.
REQ-015 One message SHALL occupy exactly 10 x NCHARS x CLKS_PER_BIT cycles, where NCHARS = 4 or 2.
REQ-016 If out_load=1 while not IDLE, SHALL store out_val in a single pending register and set pending valid; a second strobe before the pending value is consumed SHALL overwrite it and set overrun.
REQ-017 When out_load=1 coincides with the last cycle of the final STOP bit, the new value SHALL go to pending and be sent next, with no loss and no overrun.
REQ-018 A message in flight SHALL never be modified by out_load; out_val SHALL only be sampled when out_load=1.
REQ-019 busy SHALL equal (state != IDLE) OR pending valid; it is registered, with no combinational path from out_load.
REQ-020 The baud counter SHALL count down from CLKS_PER_BIT-1 to 0 and reload; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-021 overrun SHALL clear only on reset.

Reset
REQ-022 While reset=0: uart_tx=1, busy=0, overrun=0, state=IDLE, pending valid=0, counters=0, independent of clk.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (line returns high); no partial char resumes after release.
REQ-024 Reset deassertion SHALL be synchronised internally (2-flop) before it releases the FSM.

Structure
REQ-025 uart_state_t (IDLE, START, DATA, STOP) and the ASCII_CR and ASCII_LF constants SHALL live in arch_defs_pkg; DATA_WIDTH SHALL come from arch_defs_pkg.
REQ-026 The baud-tick counter SHALL be a sub-module uart_baud_gen (ports clk, reset, restart, tick), reused by later UART blocks.
REQ-027 The nibble-to-ASCII conversion SHALL be a function inside output_uart_tx.

Verification (CLKS_PER_BIT=4, SEND_CRLF=1 unless noted)
REQ-028 Reset -> uart_tx=1, busy=0, overrun=0; release, then strobe out_val=0xFF -> uart_tx low at the next cycle; decoded bytes 0x46,0x46,0x0D,0x0A; busy low after 160 cycles.
REQ-029 Strobe 0x00 (the ADD_CZ result) -> bytes 0x30,0x30,0x0D,0x0A; each bit is exactly 4 cycles wide, checked at bit centres.
REQ-030 Strobe 0x3A, strobe 0xC5 at cycle 20, strobe 0x7E at cycle 30 -> messages "3A" then "7E" are sent back to back with no gap; "C5" is dropped; overrun=1.
REQ-031 Strobe 0x12, then a second strobe 0x34 on the final STOP cycle -> "12" then "34" are sent; overrun stays 0.
REQ-032 Assert reset at cycle 50 of a message -> uart_tx=1 within the same cycle, busy=0; after release the line stays idle until a new strobe.
REQ-033 With SEND_CRLF=0, strobe 0xA5 -> bytes 0x41,0x35 only; busy is high for exactly 80 cycles.
